vdma_wr_burst_engine: RTL and testbench

VDMA_WR_BURST_ENGINE -- requirements
Module: vdma_wr_burst_engine

---
 rtl/vdma_wr_pkg.sv | 15 +
 rtl/vdma_wr_burst_engine_if.sv | 47 ++++
 rtl/vdma_wr_addr_gen.sv | 103 ++++++++++
 rtl/vdma_wr_burst_engine.sv | 169 ++++++++++++++++
 tb/tb_vdma_wr_burst_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vdma_wr_pkg.sv
// Shared types and AXI constants for the VDMA write burst engine.
// Holds the burst FSM state encoding and the AXI burst/response codes.
package vdma_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/vdma_wr_burst_engine_if.sv
// AXI4 write-channel bundle (AW, W, B) for the VDMA write burst engine.
// master: the engine (drives AW/W, bready); slave: the memory side.
interface vdma_wr_burst_engine_if #(
    parameter int ASIZE     = 29,
    parameter int IDSIZE    = 4,
    parameter int LSIZE     = 9,
    parameter int AXI_DSIZE = 256
) ();

    logic [IDSIZE-1:0]      axi_awid;
    logic [ASIZE-1:0]       axi_awaddr;
    logic [LSIZE-1:0]       axi_awlen;
    logic [2:0]             axi_awsize;
    logic [1:0]             axi_awburst;
    logic                   axi_awvalid;
    logic                   axi_awready;
    logic [AXI_DSIZE-1:0]   axi_wdata;
    logic [AXI_DSIZE/8-1:0] axi_wstrb;
    logic                   axi_wlast;
    logic                   axi_wvalid;
    logic                   axi_wready;
    logic [IDSIZE-1:0]      axi_bid;
    logic [1:0]             axi_bresp;
    logic                   axi_bvalid;
    logic                   axi_bready;

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize,
        output axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready
    );

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize,
        input  axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready
    );

endinterface

// File: rtl/vdma_wr_addr_gen.sv
// Frame/line/beat bookkeeping: base address, beat offset, line count,
// frame arming and completion. Ports: fsync/base/stride/geometry in;
// busy/retire from the FSM; go, len, addr and frame_done out.
module vdma_wr_addr_gen #(
    parameter int ASIZE      = 29,
    parameter int BURST_LEN  = 128,
    parameter int BYTES_LOG2 = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             fsync_i,
    input  logic [ASIZE-1:0] baseaddr_i,
    input  logic [ASIZE-1:0] line_stride_i,
    input  logic [15:0]      line_beats_i,
    input  logic [15:0]      vlines_i,
    input  logic             busy_i,
    input  logic             retire_i,
    input  logic [15:0]      retire_len_i,
    output logic             go_o,
    output logic [15:0]      len_o,
    output logic [ASIZE-1:0] addr_o,
    output logic             frame_done_o
);

    logic [ASIZE-1:0] line_base_q, line_base_d;
    logic [ASIZE-1:0] sync_base_q, sync_base_d;
    logic [15:0]      beat_off_q, beat_off_d;
    logic [15:0]      line_cnt_q, line_cnt_d;
    logic             armed_q, armed_d;
    logic             sync_pend_q, sync_pend_d;
    logic [15:0]      remain;
    logic [16:0]      beat_sum;
    logic             done;
    logic             activate;

    assign remain = line_beats_i - beat_off_q;
    assign len_o  = (remain > 16'(BURST_LEN)) ? 16'(BURST_LEN) : remain;
    assign addr_o = line_base_q + (ASIZE'(beat_off_q) << BYTES_LOG2);

    // An empty geometry completes the frame on the first armed cycle.
    assign done = armed_q && (line_beats_i == 16'd0 ||
                              vlines_i == 16'd0 ||
                              line_cnt_q >= vlines_i);
    assign frame_done_o = done;
    assign go_o         = armed_q && !done;

    assign beat_sum = {1'b0, beat_off_q} + {1'b0, retire_len_i};

    // A frame sync seen mid-burst is parked until the burst retires.
    assign activate = (fsync_i && (!busy_i || retire_i)) ||
                      (retire_i && sync_pend_q);

    always_comb begin
        line_base_d = line_base_q;
        sync_base_d = sync_base_q;
        beat_off_d  = beat_off_q;
        line_cnt_d  = line_cnt_q;
        armed_d     = armed_q;
        sync_pend_d = sync_pend_q;
        if (done) begin
            armed_d = 1'b0;
        end
        if (retire_i) begin
            if (beat_sum >= {1'b0, line_beats_i}) begin
                beat_off_d  = 16'd0;
                line_base_d = line_base_q + line_stride_i;
                line_cnt_d  = line_cnt_q + 16'd1;
            end else begin
                beat_off_d = beat_sum[15:0];
            end
        end
        if (fsync_i && busy_i && !retire_i) begin
            sync_pend_d = 1'b1;
            sync_base_d = baseaddr_i;
        end
        if (activate) begin
            line_base_d = fsync_i ? baseaddr_i : sync_base_q;
            beat_off_d  = 16'd0;
            line_cnt_d  = 16'd0;
            armed_d     = 1'b1;
            sync_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_base_q <= '0;
            sync_base_q <= '0;
            beat_off_q  <= '0;
            line_cnt_q  <= '0;
            armed_q     <= 1'b0;
            sync_pend_q <= 1'b0;
        end else begin
            line_base_q <= line_base_d;
            sync_base_q <= sync_base_d;
            beat_off_q  <= beat_off_d;
            line_cnt_q  <= line_cnt_d;
            armed_q     <= armed_d;
            sync_pend_q <= sync_pend_d;
        end
    end

endmodule

// File: rtl/vdma_wr_burst_engine.sv
// VDMA write burst engine: moves FIFO words to AXI as single-outstanding
// INCR bursts, line by line. Ports: clock/reset, frame control (enable,
// fsync, geometry), FIFO (count/data/rd_en), status (frame_done,
// bresp_err, pend_in/pend_out) and the AXI write bundle `axi`.
// Optional feature macro: VDMA_WR_PEND_EN (external pend hold/report).
module vdma_wr_burst_engine
    import vdma_wr_pkg::*;
#(
    parameter int ASIZE     = 29,
    parameter int IDSIZE    = 4,
    parameter int ID        = 0,
    parameter int LSIZE     = 9,
    parameter int AXI_DSIZE = 256,
    parameter int BURST_LEN = 128
) (
    input  logic                 axi_aclk,
    input  logic                 axi_resetn,
    input  logic                 enable,
    input  logic                 fsync,
    input  logic [ASIZE-1:0]     baseaddr,
    input  logic [ASIZE-1:0]     line_stride,
    input  logic [15:0]          line_beats,
    input  logic [15:0]          vlines,
    input  logic [9:0]           fifo_count,
    input  logic [AXI_DSIZE-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic                 frame_done,
    output logic                 bresp_err,
    input  logic                 pend_in,
    output logic                 pend_out,
    vdma_wr_burst_engine_if.master axi
);

    localparam int BYTES_LOG2 = $clog2(AXI_DSIZE / 8);

    state_e           state_q, state_d;
    logic [ASIZE-1:0] awaddr_q, awaddr_d;
    logic [LSIZE-1:0] awlen_q, awlen_d;
    logic [15:0]      len_q, len_d;
    logic [15:0]      beat_q, beat_d;
    logic             bresp_err_q, bresp_err_d;
    logic             go;
    logic [15:0]      len;
    logic [ASIZE-1:0] addr;
    logic             pend_ok;
    logic             start;
    logic             retire;
    logic             wvalid;
    logic             wlast;
    logic             unused_bid;

    vdma_wr_addr_gen #(
        .ASIZE      (ASIZE),
        .BURST_LEN  (BURST_LEN),
        .BYTES_LOG2 (BYTES_LOG2)
    ) u_addr_gen (
        .clk_i         (axi_aclk),
        .rst_ni        (axi_resetn),
        .fsync_i       (fsync),
        .baseaddr_i    (baseaddr),
        .line_stride_i (line_stride),
        .line_beats_i  (line_beats),
        .vlines_i      (vlines),
        .busy_i        (state_q != IDLE),
        .retire_i      (retire),
        .retire_len_i  (len_q),
        .go_o          (go),
        .len_o         (len),
        .addr_o        (addr),
        .frame_done_o  (frame_done)
    );

`ifdef VDMA_WR_PEND_EN
    assign pend_ok  = !pend_in;
    assign pend_out = (state_q != IDLE);
`else
    logic unused_pend;
    assign unused_pend = pend_in;
    assign pend_ok     = 1'b1;
    assign pend_out    = 1'b0;
`endif

    assign unused_bid = ^axi.axi_bid;

    // A same-cycle fsync wins over starting a burst of the old frame.
    assign start = go && !fsync && enable && pend_ok &&
                   (len != 16'd0) && ({6'd0, fifo_count} >= len);

    // W is withheld while the FIFO is empty so it can never be over-read.
    assign wvalid = (state_q == DATA) && (fifo_count != 10'd0);
    assign wlast  = (state_q == DATA) && (beat_q == len_q - 16'd1);

    assign axi.axi_awid    = IDSIZE'(ID);
    assign axi.axi_awaddr  = awaddr_q;
    assign axi.axi_awlen   = awlen_q;
    assign axi.axi_awsize  = 3'(BYTES_LOG2);
    assign axi.axi_awburst = AXI_BURST_INCR;
    assign axi.axi_awvalid = (state_q == ADDR);
    assign axi.axi_wdata   = fifo_data;
    assign axi.axi_wstrb   = '1;
    assign axi.axi_wlast   = wlast;
    assign axi.axi_wvalid  = wvalid;
    assign axi.axi_bready  = (state_q == RESP);
    assign fifo_rd_en      = wvalid && axi.axi_wready;
    assign bresp_err       = bresp_err_q;

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        len_d       = len_q;
        beat_d      = beat_q;
        bresp_err_d = bresp_err_q;
        retire      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ADDR;
                    awaddr_d = addr;
                    awlen_d  = LSIZE'(len - 16'd1);
                    len_d    = len;
                end
            end
            ADDR: begin
                if (axi.axi_awready) begin
                    state_d = DATA;
                    beat_d  = 16'd0;
                end
            end
            DATA: begin
                if (fifo_rd_en) begin
                    beat_d = beat_q + 16'd1;
                    if (wlast) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (axi.axi_bvalid) begin
                    state_d = IDLE;
                    retire  = 1'b1;
                    if (axi.axi_bresp != AXI_RESP_OKAY) begin
                        bresp_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= IDLE;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            bresp_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            bresp_err_q <= bresp_err_d;
        end
    end

endmodule

// File: tb/tb_vdma_wr_burst_engine.sv
// Scoreboard bench for vdma_wr_burst_engine: directed frames queue the
// expected AW/W traffic; a monitor pops and compares on each handshake.
module tb_vdma_wr_burst_engine;

    localparam int ASIZE  = 29;
    localparam int IDSIZE = 4;
    localparam int LSIZE  = 9;
    localparam int DW     = 256;

    typedef struct packed {
        logic [ASIZE-1:0] addr;
        logic [LSIZE-1:0] len;
    } aw_t;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } w_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b1;
    logic             fsync = 1'b0;
    logic [ASIZE-1:0] baseaddr = '0;
    logic [ASIZE-1:0] line_stride = '0;
    logic [15:0]      line_beats = '0;
    logic [15:0]      vlines = '0;
    logic [9:0]       fifo_count = 10'd512;
    logic [DW-1:0]    fifo_data;
    logic             fifo_rd_en;
    logic             frame_done;
    logic             bresp_err;
    logic             pend_in = 1'b0;
    logic             pend_out;

    logic [31:0] fifo_head = 32'd0;
    logic [31:0] exp_word = 32'd0;
    logic        pop_pend = 1'b0;
    logic        toggle = 1'b0;
    logic        err_mode = 1'b0;
    int          b_cnt = 0;
    int          done_cnt = 0;
    int          rd_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    aw_t         aw_q[$];
    w_t          w_q[$];

    always #5 clk = ~clk;

    assign fifo_data = {8{fifo_head}};

    vdma_wr_burst_engine_if #(
        .ASIZE(ASIZE), .IDSIZE(IDSIZE), .LSIZE(LSIZE), .AXI_DSIZE(DW)
    ) axi ();

    vdma_wr_burst_engine #(
        .ASIZE(ASIZE), .IDSIZE(IDSIZE), .ID(0), .LSIZE(LSIZE),
        .AXI_DSIZE(DW), .BURST_LEN(128)
    ) dut (
        .axi_aclk    (clk),
        .axi_resetn  (rst_n),
        .enable      (enable),
        .fsync       (fsync),
        .baseaddr    (baseaddr),
        .line_stride (line_stride),
        .line_beats  (line_beats),
        .vlines      (vlines),
        .fifo_count  (fifo_count),
        .fifo_data   (fifo_data),
        .fifo_rd_en  (fifo_rd_en),
        .frame_done  (frame_done),
        .bresp_err   (bresp_err),
        .pend_in     (pend_in),
        .pend_out    (pend_out),
        .axi         (axi)
    );

    task automatic chk(string name, logic [255:0] got, logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Slave + FIFO model: change inputs just after the active edge.
    initial begin
        axi.axi_awready = 1'b1;
        axi.axi_wready  = 1'b1;
        axi.axi_bvalid  = 1'b1;
        axi.axi_bresp   = 2'b00;
        axi.axi_bid     = '0;
        forever begin
            @(posedge clk);
            #2;
            if (pop_pend) begin
                fifo_head = fifo_head + 32'd1;
                pop_pend  = 1'b0;
            end
            axi.axi_wready = toggle ? ~axi.axi_wready : 1'b1;
            axi.axi_bresp  = (err_mode && b_cnt == 1) ? 2'b10 : 2'b00;
        end
    end

    // Monitor: sample at the falling edge, compare against queued traffic.
    initial begin
        aw_t ea;
        w_t  ew;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (axi.axi_awvalid && axi.axi_awready) begin
                    chk("aw_expected", aw_q.size() > 0, 1);
                    if (aw_q.size() > 0) begin
                        ea = aw_q.pop_front();
                        chk("awaddr", axi.axi_awaddr, ea.addr);
                        chk("awlen", axi.axi_awlen, ea.len);
                        chk("awsize", axi.axi_awsize, 5);
                        chk("awburst", axi.axi_awburst, 1);
                        chk("awid", axi.axi_awid, 0);
                    end
                end
                if (axi.axi_wvalid && axi.axi_wready) begin
                    chk("w_expected", w_q.size() > 0, 1);
                    chk("rd_en_on_hs", fifo_rd_en, 1);
                    chk("rd_on_empty", fifo_count == 10'd0, 0);
                    if (w_q.size() > 0) begin
                        ew = w_q.pop_front();
                        chk("wdata", axi.axi_wdata, {8{ew.word}});
                        chk("wlast", axi.axi_wlast, ew.last);
                        chk("wstrb", axi.axi_wstrb, 32'hFFFF_FFFF);
                    end
                    pop_pend = 1'b1;
                    rd_cnt++;
                end else if (fifo_rd_en) begin
                    chk("rd_en_no_hs", fifo_rd_en, 0);
                end
                if (axi.axi_bvalid && axi.axi_bready) b_cnt++;
                if (frame_done) done_cnt++;
            end
        end
    end

    task automatic push_burst(logic [ASIZE-1:0] a, int len);
        aw_t ea;
        w_t  ew;
        ea.addr = a;
        ea.len  = LSIZE'(len - 1);
        aw_q.push_back(ea);
        for (int i = 0; i < len; i++) begin
            ew.word = exp_word;
            ew.last = (i == len - 1);
            w_q.push_back(ew);
            exp_word = exp_word + 32'd1;
        end
    endtask

    task automatic frame(logic [ASIZE-1:0] b, logic [ASIZE-1:0] s,
                         int lb, int vl);
        baseaddr    = b;
        line_stride = s;
        line_beats  = 16'(lb);
        vlines      = 16'(vl);
        @(posedge clk);
        #1 fsync = 1'b1;
        @(posedge clk);
        #1 fsync = 1'b0;
    endtask

    task automatic wait_done(int target, string name);
        int n = 0;
        while (done_cnt < target && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk(name, done_cnt, target);
        repeat (10) @(posedge clk);
        chk({name, "_once"}, done_cnt, target);
        chk({name, "_aw_drained"}, aw_q.size(), 0);
        chk({name, "_w_drained"}, w_q.size(), 0);
    endtask

    task automatic wait_rd(int n, string name);
        int c = 0;
        while (rd_cnt < n && c < 2000) begin
            @(posedge clk);
            c++;
        end
        chk(name, rd_cnt >= n, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awvalid", axi.axi_awvalid, 0);
        chk("rst_wvalid", axi.axi_wvalid, 0);
        chk("rst_bready", axi.axi_bready, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_bresp_err", bresp_err, 0);
        chk("rst_pend_out", pend_out, 0);
        chk("rst_awaddr", axi.axi_awaddr, 0);
        chk("rst_awlen", axi.axi_awlen, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Two full lines, two bursts each.
        push_burst(29'h0002_0000, 128);
        push_burst(29'h0002_1000, 128);
        push_burst(29'h0002_4000, 128);
        push_burst(29'h0002_5000, 128);
        frame(29'h0002_0000, 29'h0000_4000, 256, 2);
        wait_done(1, "s1_done");

        // Short tail burst.
        push_burst(29'h0040_0000, 128);
        push_burst(29'h0040_1000, 72);
        frame(29'h0040_0000, 29'h0000_2000, 200, 1);
        wait_done(2, "s2_done");

        // Toggling wready.
        toggle = 1'b1;
        rd_cnt = 0;
        push_burst(29'h0080_0000, 16);
        frame(29'h0080_0000, 29'h0000_1000, 16, 1);
        wait_done(3, "s3_done");
        chk("s3_rd_pulses", rd_cnt, 16);
        toggle = 1'b0;
        @(posedge clk);

        // fsync during DATA: current burst finishes, new frame follows.
        rd_cnt = 0;
        push_burst(29'h0001_0000, 128);
        push_burst(29'h0010_0000, 128);
        push_burst(29'h0010_1000, 128);
        push_burst(29'h0010_4000, 128);
        push_burst(29'h0010_5000, 128);
        frame(29'h0001_0000, 29'h0000_4000, 256, 2);
        wait_rd(10, "s4_reach_data");
        chk("s4_in_data", axi.axi_wvalid, 1);
        frame(29'h0010_0000, 29'h0000_4000, 256, 2);
        wait_done(4, "s4_done");

        // Empty geometry: done the cycle after fsync, no traffic.
        frame(29'h0000_0000, 29'h0000_1000, 0, 3);
        @(negedge clk);
        chk("s5_lb0_pulse", frame_done, 1);
        @(negedge clk);
        chk("s5_lb0_clear", frame_done, 0);
        frame(29'h0000_0000, 29'h0000_1000, 64, 0);
        @(negedge clk);
        chk("s5_vl0_pulse", frame_done, 1);
        @(negedge clk);
        chk("s5_vl0_clear", frame_done, 0);
        repeat (5) @(posedge clk);
        chk("s5_count", done_cnt, 6);

        // FIFO level one short of len blocks; exactly len starts.
        fifo_count = 10'd127;
        push_burst(29'h0020_0000, 128);
        frame(29'h0020_0000, 29'h0000_1000, 128, 1);
        repeat (20) @(posedge clk);
        #1 chk("s6_fifo_block", axi.axi_awvalid, 0);
        fifo_count = 10'd128;
        wait_done(7, "s6_done");
        fifo_count = 10'd512;

        // enable low holds off new bursts.
        enable = 1'b0;
        push_burst(29'h0030_0000, 64);
        frame(29'h0030_0000, 29'h0000_1000, 64, 1);
        repeat (20) @(posedge clk);
        #1 chk("s7_enable_block", axi.axi_awvalid, 0);
        enable = 1'b1;
        wait_done(8, "s7_done");

        // Error response on the second burst is sticky.
        chk("s8_err_before", bresp_err, 0);
        b_cnt    = 0;
        err_mode = 1'b1;
        push_burst(29'h0050_0000, 128);
        push_burst(29'h0050_1000, 128);
        frame(29'h0050_0000, 29'h0000_2000, 256, 1);
        wait_done(9, "s8_done");
        chk("s8_err_set", bresp_err, 1);
        err_mode = 1'b0;
        push_burst(29'h0060_0000, 32);
        frame(29'h0060_0000, 29'h0000_1000, 32, 1);
        wait_done(10, "s8_more_done");
        chk("s8_err_sticky", bresp_err, 1);

        // Reset mid-burst abandons it for good.
        rd_cnt = 0;
        push_burst(29'h0070_0000, 128);
        frame(29'h0070_0000, 29'h0000_1000, 128, 1);
        wait_rd(5, "s9_reach_data");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("s9_rst_wvalid", axi.axi_wvalid, 0);
        chk("s9_rst_rd_en", fifo_rd_en, 0);
        chk("s9_rst_awaddr", axi.axi_awaddr, 0);
        chk("s9_rst_err", bresp_err, 0);
        aw_q.delete();
        w_q.delete();
        repeat (3) @(posedge clk);
        #3 exp_word = fifo_head;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 chk("s9_no_resume", axi.axi_awvalid, 0);
        chk("s9_no_bready", axi.axi_bready, 0);
        push_burst(29'h0071_0000, 16);
        frame(29'h0071_0000, 29'h0000_1000, 16, 1);
        wait_done(11, "s9_after_done");

`ifdef VDMA_WR_PEND_EN
        pend_in = 1'b1;
        push_burst(29'h0090_0000, 32);
        frame(29'h0090_0000, 29'h0000_1000, 32, 1);
        repeat (20) @(posedge clk);
        #1 chk("pend_block", axi.axi_awvalid, 0);
        chk("pend_out_idle", pend_out, 0);
        @(posedge clk);
        #1 pend_in = 1'b0;
        @(posedge clk);
        #1 chk("pend_release_aw", axi.axi_awvalid, 1);
        chk("pend_out_addr", pend_out, 1);
        begin
            int c = 0;
            while (!axi.axi_bready && c < 200) begin
                @(posedge clk);
                #1 c++;
            end
        end
        chk("pend_out_resp", pend_out, 1);
        wait_done(12, "pend_done");
        chk("pend_out_after", pend_out, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
